// File: rtl/bcd_calc_core.sv
// Signed sign-magnitude BCD calculator core: keypad entry, digit-serial
// add/subtract (MSD-first compare, LSD-first ALU), memory register and display mux.
module bcd_calc_core #(
    parameter int DIGITS = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                dig_strobe,
    input  logic [3:0]          dig_code,
    input  logic                op_strobe,
    input  logic [1:0]          op_code,
    input  logic                ex_strobe,
    input  logic                clear_strobe,
    input  logic                neg_strobe,
    input  logic                bksp_strobe,
    input  logic                ms_strobe,
    input  logic                mr_strobe,
    input  logic                mc_strobe,
    output logic [4*DIGITS-1:0] disp_bcd,
    output logic                disp_neg,
    output logic [2:0]          state_led,
    output logic                busy,
    output logic                error,
    output logic                mem_valid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [1:0] CMP_EQ = 2'd0;
    localparam logic [1:0] CMP_GT = 2'd1;
    localparam logic [1:0] CMP_LT = 2'd2;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'b000,
        ST_OP_SEL   = 3'b001,
        ST_ENTER_B  = 3'b010,
        ST_EXEC_CMP = 3'b011,
        ST_EXEC_ALU = 3'b100,
        ST_RESULT   = 3'b101,
        ST_ERROR    = 3'b110
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_mag_q, a_mag_d, b_mag_q, b_mag_d, m_mag_q, m_mag_d;
    logic            a_sign_q, a_sign_d, b_sign_q, b_sign_d, m_sign_q, m_sign_d;
    logic [CW-1:0]   a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic            mem_valid_q, mem_valid_d;
    logic            op_sub_q, op_sub_d;
    logic            show_b_q, show_b_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [1:0]      cmp_q, cmp_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    res_q, res_d;

    function automatic logic [CW-1:0] sig_count(input logic [W-1:0] mag);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (mag[4*i +: 4] != 4'd0) n = CW'(i + 1);
        end
        return n;
    endfunction

    function automatic logic [3:0] nib_at(input logic [W-1:0] v, input logic [CW-1:0] idx);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == CW'(i)) n = v[4*i +: 4];
        end
        return n;
    endfunction

    function automatic logic [W-1:0] nib_set(input logic [W-1:0] v, input logic [CW-1:0] idx,
                                             input logic [3:0] n);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == CW'(i)) r[4*i +: 4] = n;
        end
        return r;
    endfunction

    // Strobe arbitration: exactly one (the highest-priority asserted) strobe acts.
    logic do_clear, do_ex, do_op, do_neg, do_bksp, do_dig, do_ms, do_mr, do_mc;
    always_comb begin
        do_clear = clear_strobe;
        do_ex    = ex_strobe   & ~clear_strobe;
        do_op    = op_strobe   & ~(clear_strobe | ex_strobe);
        do_neg   = neg_strobe  & ~(clear_strobe | ex_strobe | op_strobe);
        do_bksp  = bksp_strobe & ~(clear_strobe | ex_strobe | op_strobe | neg_strobe);
        do_dig   = dig_strobe  & ~(clear_strobe | ex_strobe | op_strobe | neg_strobe
                                   | bksp_strobe);
        do_ms    = ms_strobe   & ~(clear_strobe | ex_strobe | op_strobe | neg_strobe
                                   | bksp_strobe | dig_strobe);
        do_mr    = mr_strobe   & ~(clear_strobe | ex_strobe | op_strobe | neg_strobe
                                   | bksp_strobe | dig_strobe | ms_strobe);
        do_mc    = mc_strobe   & ~(clear_strobe | ex_strobe | op_strobe | neg_strobe
                                   | bksp_strobe | dig_strobe | ms_strobe | mr_strobe);
    end

    logic          in_exec, idle, dig_ok, last_cyc;
    logic [W-1:0]  dig_ext;
    logic          a_can_push, b_can_push;

    always_comb begin
        in_exec    = (state_q == ST_EXEC_CMP) || (state_q == ST_EXEC_ALU);
        idle       = !in_exec && (state_q != ST_ERROR);
        dig_ok     = (dig_code <= 4'd9);
        last_cyc   = (cyc_q == CW'(DIGITS - 1));
        dig_ext    = '0;
        dig_ext[3:0] = dig_code;
        // A leading zero is never stored, so count always equals significant digits.
        a_can_push = (a_cnt_q < CW'(DIGITS)) && !((a_cnt_q == '0) && (dig_code == 4'd0));
        b_can_push = (b_cnt_q < CW'(DIGITS)) && !((b_cnt_q == '0) && (dig_code == 4'd0));
    end

    // Digit-serial datapath
    logic [3:0] a_nib, b_nib, x_nib, y_nib, alu_nib, cmp_a, cmp_b;
    logic [4:0] sum5, sub5;
    logic       eff_add, alu_cout, res_sign;
    logic [W-1:0] res_full;

    always_comb begin
        cmp_a    = nib_at(a_mag_q, CW'(DIGITS - 1) - cyc_q);
        cmp_b    = nib_at(b_mag_q, CW'(DIGITS - 1) - cyc_q);
        a_nib    = nib_at(a_mag_q, cyc_q);
        b_nib    = nib_at(b_mag_q, cyc_q);
        eff_add  = (a_sign_q == (b_sign_q ^ op_sub_q));
        x_nib    = (cmp_q == CMP_LT) ? b_nib : a_nib;
        y_nib    = (cmp_q == CMP_LT) ? a_nib : b_nib;
        sum5     = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, carry_q};
        sub5     = {1'b0, x_nib} - {1'b0, y_nib} - {4'd0, carry_q};
        alu_nib  = 4'd0;
        alu_cout = 1'b0;
        if (eff_add) begin
            if (sum5 > 5'd9) begin
                alu_nib  = 4'(sum5 - 5'd10);
                alu_cout = 1'b1;
            end else begin
                alu_nib  = sum5[3:0];
            end
        end else begin
            if (sub5[4]) begin
                alu_nib  = 4'(sub5 + 5'd10);
                alu_cout = 1'b1;
            end else begin
                alu_nib  = sub5[3:0];
            end
        end
        res_full = nib_set(res_q, cyc_q, alu_nib);
        if (eff_add)               res_sign = a_sign_q;
        else if (cmp_q == CMP_GT)  res_sign = a_sign_q;
        else if (cmp_q == CMP_LT)  res_sign = b_sign_q ^ op_sub_q;
        else                       res_sign = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        a_mag_d     = a_mag_q;
        a_sign_d    = a_sign_q;
        a_cnt_d     = a_cnt_q;
        b_mag_d     = b_mag_q;
        b_sign_d    = b_sign_q;
        b_cnt_d     = b_cnt_q;
        m_mag_d     = m_mag_q;
        m_sign_d    = m_sign_q;
        mem_valid_d = mem_valid_q;
        op_sub_d    = op_sub_q;
        show_b_d    = show_b_q;
        cyc_d       = cyc_q;
        cmp_d       = cmp_q;
        carry_d     = carry_q;
        res_d       = res_q;

        case (state_q)
            ST_EXEC_CMP: begin
                if ((cmp_q == CMP_EQ) && (cmp_a != cmp_b)) begin
                    cmp_d = (cmp_a > cmp_b) ? CMP_GT : CMP_LT;
                end
                if (last_cyc) begin
                    cyc_d   = '0;
                    carry_d = 1'b0;
                    res_d   = '0;
                    state_d = ST_EXEC_ALU;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_EXEC_ALU: begin
                res_d   = res_full;
                carry_d = alu_cout;
                if (last_cyc) begin
                    if (eff_add && alu_cout) begin
                        state_d = ST_ERROR;
                    end else begin
                        a_mag_d  = res_full;
                        a_sign_d = res_sign;
                        a_cnt_d  = sig_count(res_full);
                        state_d  = ST_RESULT;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: ;
        endcase

        if (do_clear) begin
            a_mag_d  = '0;
            a_sign_d = 1'b0;
            a_cnt_d  = '0;
            b_mag_d  = '0;
            b_sign_d = 1'b0;
            b_cnt_d  = '0;
            state_d  = ST_ENTER_A;
        end else if (idle) begin
            if (do_ex) begin
                if ((state_q == ST_ENTER_B) || (state_q == ST_RESULT)) begin
                    show_b_d = (state_q == ST_ENTER_B);
                    cyc_d    = '0;
                    cmp_d    = CMP_EQ;
                    state_d  = ST_EXEC_CMP;
                end
            end else if (do_op) begin
                if (!op_code[1]) begin
                    if ((state_q == ST_ENTER_A) || (state_q == ST_RESULT)) begin
                        op_sub_d = op_code[0];
                        b_mag_d  = '0;
                        b_sign_d = 1'b0;
                        b_cnt_d  = '0;
                        state_d  = ST_OP_SEL;
                    end else if (state_q == ST_OP_SEL) begin
                        op_sub_d = op_code[0];
                    end
                end
            end else if (do_neg) begin
                if ((state_q == ST_ENTER_A) || (state_q == ST_RESULT)) a_sign_d = ~a_sign_q;
                else if (state_q == ST_ENTER_B)                        b_sign_d = ~b_sign_q;
            end else if (do_bksp) begin
                if (state_q == ST_ENTER_A) begin
                    a_mag_d = a_mag_q >> 4;
                    if (a_cnt_q != '0) a_cnt_d = a_cnt_q - CW'(1);
                end else if (state_q == ST_ENTER_B) begin
                    b_mag_d = b_mag_q >> 4;
                    if (b_cnt_q != '0) b_cnt_d = b_cnt_q - CW'(1);
                end
            end else if (do_dig) begin
                if (dig_ok) begin
                    case (state_q)
                        ST_ENTER_A: if (a_can_push) begin
                            a_mag_d = (a_mag_q << 4) | dig_ext;
                            a_cnt_d = a_cnt_q + CW'(1);
                        end
                        ST_ENTER_B: if (b_can_push) begin
                            b_mag_d = (b_mag_q << 4) | dig_ext;
                            b_cnt_d = b_cnt_q + CW'(1);
                        end
                        ST_OP_SEL: begin
                            b_mag_d  = dig_ext;
                            b_sign_d = 1'b0;
                            b_cnt_d  = (dig_code != 4'd0) ? CW'(1) : '0;
                            state_d  = ST_ENTER_B;
                        end
                        ST_RESULT: begin
                            a_mag_d  = dig_ext;
                            a_sign_d = 1'b0;
                            a_cnt_d  = (dig_code != 4'd0) ? CW'(1) : '0;
                            state_d  = ST_ENTER_A;
                        end
                        default: ;
                    endcase
                end
            end else if (do_ms) begin
                if ((state_q == ST_ENTER_A) || (state_q == ST_RESULT)) begin
                    m_mag_d     = a_mag_q;
                    m_sign_d    = a_sign_q;
                    mem_valid_d = 1'b1;
                end else if (state_q == ST_ENTER_B) begin
                    m_mag_d     = b_mag_q;
                    m_sign_d    = b_sign_q;
                    mem_valid_d = 1'b1;
                end
            end else if (do_mr) begin
                if (mem_valid_q) begin
                    if ((state_q == ST_ENTER_A) || (state_q == ST_RESULT)) begin
                        a_mag_d  = m_mag_q;
                        a_sign_d = m_sign_q;
                        a_cnt_d  = sig_count(m_mag_q);
                        state_d  = ST_ENTER_A;
                    end else begin
                        b_mag_d  = m_mag_q;
                        b_sign_d = m_sign_q;
                        b_cnt_d  = sig_count(m_mag_q);
                        state_d  = ST_ENTER_B;
                    end
                end
            end else if (do_mc) begin
                m_mag_d     = '0;
                m_sign_d    = 1'b0;
                mem_valid_d = 1'b0;
            end
        end

        // Zero is always positive, whichever path produced it.
        if (a_mag_d == '0) a_sign_d = 1'b0;
        if (b_mag_d == '0) b_sign_d = 1'b0;
        if (m_mag_d == '0) m_sign_d = 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_ENTER_A;
            a_mag_q     <= '0;
            a_sign_q    <= 1'b0;
            a_cnt_q     <= '0;
            b_mag_q     <= '0;
            b_sign_q    <= 1'b0;
            b_cnt_q     <= '0;
            m_mag_q     <= '0;
            m_sign_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            op_sub_q    <= 1'b0;
            show_b_q    <= 1'b0;
            cyc_q       <= '0;
            cmp_q       <= CMP_EQ;
            carry_q     <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_mag_q     <= a_mag_d;
            a_sign_q    <= a_sign_d;
            a_cnt_q     <= a_cnt_d;
            b_mag_q     <= b_mag_d;
            b_sign_q    <= b_sign_d;
            b_cnt_q     <= b_cnt_d;
            m_mag_q     <= m_mag_d;
            m_sign_q    <= m_sign_d;
            mem_valid_q <= mem_valid_d;
            op_sub_q    <= op_sub_d;
            show_b_q    <= show_b_d;
            cyc_q       <= cyc_d;
            cmp_q       <= cmp_d;
            carry_q     <= carry_d;
            res_q       <= res_d;
        end
    end

    // A and B stay untouched during execution, so the held display is re-derived.
    logic [W-1:0] disp_mag;
    logic         disp_sgn;
    always_comb begin
        disp_mag = a_mag_q;
        disp_sgn = a_sign_q;
        if ((state_q == ST_ENTER_B) || (in_exec && show_b_q)) begin
            disp_mag = b_mag_q;
            disp_sgn = b_sign_q;
        end
        if (state_q == ST_ERROR) begin
            disp_bcd = {DIGITS{4'hE}};
            disp_neg = 1'b0;
        end else begin
            disp_bcd = disp_mag;
            disp_neg = disp_sgn & (|disp_mag);
        end
    end

    assign state_led = state_q;
    assign busy      = in_exec;
    assign error     = (state_q == ST_ERROR);
    assign mem_valid = mem_valid_q;

endmodule

// File: tb/tb_bcd_calc_core.sv
// Bench for bcd_calc_core: directed walk through the calculator scenarios, then
// random key sequences checked against an integer-arithmetic calculator model.
module tb_bcd_calc_core;

  localparam int D   = 3;
  localparam int LIM = 1000;

  localparam int S_EA  = 0;
  localparam int S_OP  = 1;
  localparam int S_EB  = 2;
  localparam int S_RES = 5;
  localparam int S_ERR = 6;

  logic           clock = 1'b0;
  logic           resetn;
  logic           dig_strobe, op_strobe, ex_strobe, clear_strobe, neg_strobe;
  logic           bksp_strobe, ms_strobe, mr_strobe, mc_strobe;
  logic [3:0]     dig_code;
  logic [1:0]     op_code;
  logic [4*D-1:0] disp_bcd;
  logic           disp_neg, busy, error, mem_valid;
  logic [2:0]     state_led;

  int vectors = 0;
  int miscompares = 0;

  // calculator model: values as plain integers, sign as a flag
  int md_state, md_a, md_b, md_m;
  bit md_an, md_bn, md_mn, md_mv, md_sub;

  bcd_calc_core #(.DIGITS(D)) dut (
    .clock(clock), .resetn(resetn),
    .dig_strobe(dig_strobe), .dig_code(dig_code),
    .op_strobe(op_strobe), .op_code(op_code),
    .ex_strobe(ex_strobe), .clear_strobe(clear_strobe),
    .neg_strobe(neg_strobe), .bksp_strobe(bksp_strobe),
    .ms_strobe(ms_strobe), .mr_strobe(mr_strobe), .mc_strobe(mc_strobe),
    .disp_bcd(disp_bcd), .disp_neg(disp_neg), .state_led(state_led),
    .busy(busy), .error(error), .mem_valid(mem_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int ndig(input int v);
    int n;
    int t;
    n = 0;
    t = v;
    while (t > 0) begin
      n++;
      t = t / 10;
    end
    return n;
  endfunction

  task automatic model_reset();
    md_state = S_EA;
    md_a = 0; md_b = 0; md_m = 0;
    md_an = 0; md_bn = 0; md_mn = 0; md_mv = 0; md_sub = 0;
  endtask

  task automatic model_norm();
    if (md_a == 0) md_an = 0;
    if (md_b == 0) md_bn = 0;
    if (md_m == 0) md_mn = 0;
  endtask

  task automatic model_exec();
    int sa, sb, r;
    sa = md_an ? -md_a : md_a;
    sb = md_bn ? -md_b : md_b;
    r  = md_sub ? sa - sb : sa + sb;
    if (r >= LIM || r <= -LIM) begin
      md_state = S_ERR;
    end else begin
      md_a  = (r < 0) ? -r : r;
      md_an = (r < 0);
      md_state = S_RES;
    end
    model_norm();
  endtask

  task automatic model_key(input int top, input int dc, input int oc);
    if (top == 0) begin
      md_a = 0; md_b = 0; md_an = 0; md_bn = 0;
      md_state = S_EA;
    end else if (md_state != S_ERR) begin
      case (top)
        2: if (oc < 2) begin
          if (md_state == S_EA || md_state == S_RES) begin
            md_sub = oc[0]; md_b = 0; md_bn = 0; md_state = S_OP;
          end else if (md_state == S_OP) begin
            md_sub = oc[0];
          end
        end
        3: if (md_state == S_EA || md_state == S_RES) md_an = !md_an;
           else if (md_state == S_EB) md_bn = !md_bn;
        4: if (md_state == S_EA) md_a = md_a / 10;
           else if (md_state == S_EB) md_b = md_b / 10;
        5: if (dc <= 9) begin
          if (md_state == S_EA) begin
            if (ndig(md_a) < D) md_a = md_a * 10 + dc;
          end else if (md_state == S_EB) begin
            if (ndig(md_b) < D) md_b = md_b * 10 + dc;
          end else if (md_state == S_OP) begin
            md_b = dc; md_bn = 0; md_state = S_EB;
          end else if (md_state == S_RES) begin
            md_a = dc; md_an = 0; md_state = S_EA;
          end
        end
        6: if (md_state == S_EA || md_state == S_RES) begin
             md_m = md_a; md_mn = md_an; md_mv = 1;
           end else if (md_state == S_EB) begin
             md_m = md_b; md_mn = md_bn; md_mv = 1;
           end
        7: if (md_mv) begin
             if (md_state == S_EA || md_state == S_RES) begin
               md_a = md_m; md_an = md_mn; md_state = S_EA;
             end else begin
               md_b = md_m; md_bn = md_mn; md_state = S_EB;
             end
           end
        8: begin md_m = 0; md_mn = 0; md_mv = 0; end
        default: ;
      endcase
    end
    model_norm();
  endtask

  task automatic check_all(input string tag);
    logic [4*D-1:0] ed;
    logic           en;
    if (md_state == S_ERR) begin
      ed = {D{4'hE}}; en = 1'b0;
    end else if (md_state == S_EB) begin
      ed = to_bcd(md_b); en = md_bn;
    end else begin
      ed = to_bcd(md_a); en = md_an;
    end
    chk({tag, "/disp_bcd"}, disp_bcd, ed);
    chk({tag, "/disp_neg"}, disp_neg, en);
    chk({tag, "/state_led"}, state_led, md_state[2:0]);
    chk({tag, "/busy"}, busy, 1'b0);
    chk({tag, "/error"}, error, md_state == S_ERR);
    chk({tag, "/mem_valid"}, mem_valid, md_mv);
  endtask

  // mask bits by priority: 0 clear,1 ex,2 op,3 neg,4 bksp,5 dig,6 ms,7 mr,8 mc
  task automatic key(input logic [8:0] mask, input int dc, input int oc, input string tag);
    int top;
    int n;
    top = -1;
    for (int i = 8; i >= 0; i--) if (mask[i]) top = i;
    @(negedge clock);
    clear_strobe = mask[0]; ex_strobe = mask[1]; op_strobe = mask[2];
    neg_strobe = mask[3]; bksp_strobe = mask[4]; dig_strobe = mask[5];
    ms_strobe = mask[6]; mr_strobe = mask[7]; mc_strobe = mask[8];
    dig_code = 4'(dc); op_code = 2'(oc);
    @(negedge clock);
    {clear_strobe, ex_strobe, op_strobe, neg_strobe, bksp_strobe} = '0;
    {dig_strobe, ms_strobe, mr_strobe, mc_strobe} = '0;
    if (top == 1 && (md_state == S_EB || md_state == S_RES)) begin
      n = 0;
      while (busy === 1'b1 && n < 50) begin
        n++;
        @(negedge clock);
      end
      chk({tag, "/busy_cycles"}, n, 2 * D);
      model_exec();
    end else begin
      model_key(top, dc, oc);
    end
    check_all(tag);
  endtask

  task automatic k_dig(input int d);  key(9'h020, d, 0, "dig");   endtask
  task automatic k_op(input int o);   key(9'h004, 0, o, "op");    endtask
  task automatic k_ex();              key(9'h002, 0, 0, "ex");    endtask
  task automatic k_clear();           key(9'h001, 0, 0, "clear"); endtask
  task automatic k_neg();             key(9'h008, 0, 0, "neg");   endtask
  task automatic k_bksp();            key(9'h010, 0, 0, "bksp");  endtask
  task automatic k_ms();              key(9'h040, 0, 0, "ms");    endtask
  task automatic k_mr();              key(9'h080, 0, 0, "mr");    endtask
  task automatic k_mc();              key(9'h100, 0, 0, "mc");    endtask

  task automatic enter_num(input int v);
    int digs[$];
    int t;
    t = v;
    if (t == 0) digs.push_front(0);
    while (t > 0) begin
      digs.push_front(t % 10);
      t = t / 10;
    end
    foreach (digs[i]) k_dig(digs[i]);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    int r;
    int dc;
    logic [8:0] mask;
    resetn = 1'b0;
    {clear_strobe, ex_strobe, op_strobe, neg_strobe, bksp_strobe} = '0;
    {dig_strobe, ms_strobe, mr_strobe, mc_strobe} = '0;
    dig_code = 4'd0;
    op_code = 2'd0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock);
    resetn = 1'b1;

    // 123 + 456
    enter_num(123); k_op(0); enter_num(456); k_ex();
    chk("sum579/disp", disp_bcd, 12'h579);
    chk("sum579/neg", disp_neg, 1'b0);
    chk("sum579/state", state_led, 3'b101);

    // 250 - 999, then chain + 749
    k_clear(); enter_num(250); k_op(1); enter_num(999); k_ex();
    chk("sub749/disp", disp_bcd, 12'h749);
    chk("sub749/neg", disp_neg, 1'b1);
    k_op(0); enter_num(749); k_ex();
    chk("chain0/disp", disp_bcd, 12'h000);
    chk("chain0/neg", disp_neg, 1'b0);

    // overflow
    k_clear(); enter_num(999); k_op(0); enter_num(1); k_ex();
    chk("ovf/error", error, 1'b1);
    chk("ovf/disp", disp_bcd, 12'hEEE);
    chk("ovf/state", state_led, 3'b110);
    k_dig(5);
    chk("ovf_dig/disp", disp_bcd, 12'hEEE);
    k_clear();
    chk("ovf_clr/disp", disp_bcd, 12'h000);
    chk("ovf_clr/error", error, 1'b0);
    chk("ovf_clr/state", state_led, 3'b000);

    // entry limit, backspace, sign of zero
    enter_num(1234);
    chk("full/disp", disp_bcd, 12'h123);
    k_bksp();
    chk("bksp/disp", disp_bcd, 12'h012);
    k_neg();
    chk("neg/disp_neg", disp_neg, 1'b1);
    k_bksp(); k_bksp(); k_bksp();
    chk("bksp0/disp", disp_bcd, 12'h000);
    chk("bksp0/neg", disp_neg, 1'b0);

    // memory
    k_clear(); enter_num(42); k_ms();
    chk("ms/valid", mem_valid, 1'b1);
    k_clear(); k_mr();
    chk("mr/disp", disp_bcd, 12'h042);
    k_mc();
    chk("mc/valid", mem_valid, 1'b0);
    k_clear(); k_mr();
    chk("mr_ign/disp", disp_bcd, 12'h000);
    enter_num(7); k_ms();
    reset_pulse("mem_rst");
    chk("mem_rst/valid", mem_valid, 1'b0);

    // priority and abort
    enter_num(5);
    key(9'h021, 8, 0, "clr_dig");
    chk("clr_dig/disp", disp_bcd, 12'h000);
    key(9'h024, 3, 0, "op_dig");
    enter_num(321); k_op(1); enter_num(123);
    @(negedge clock);
    ex_strobe = 1'b1;
    @(negedge clock);
    ex_strobe = 1'b0;
    chk("abort/busy_start", busy, 1'b1);
    repeat (D) @(negedge clock);
    chk("abort/in_alu", state_led, 3'b100);
    #2 resetn = 1'b0;
    #1 model_reset();
    check_all("abort");
    @(negedge clock);
    resetn = 1'b1;

    // random key sequences
    for (int it = 0; it < 300; it++) begin
      r  = $urandom_range(0, 19);
      dc = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      if (md_state == S_ERR && $urandom_range(0, 1) == 0) r = 19;
      case (r)
        0, 1, 2, 3, 4, 5, 6, 7: mask = 9'h020;
        8, 9:   mask = 9'h004;
        10, 11: mask = 9'h002;
        12:     mask = 9'h008;
        13:     mask = 9'h010;
        15:     mask = 9'h040;
        16:     mask = 9'h080;
        17:     mask = 9'h100;
        18:     mask = 9'($urandom_range(0, 511)) & 9'h1FE;
        default: mask = 9'h001;
      endcase
      key(mask, dc, $urandom_range(0, 3), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_calc_core.md
Name: bcd_calc_core

Overview:
Parametrised signed BCD calculator core. It replaces the fixed 3-digit operand registers, operator register, control FSM and display mux with one block. It takes decoded one-cycle strobes from the keypad input handler and the pushbutton handler, and performs digit-serial add/subtract on sign-magnitude operands with DIGITS digits. It drives the digit/sign bus for the char_7seg decoders, plus status LEDs.

Parameters:
DIGITS, 3, BCD digits per operand/result (legal 1..8).

Ports:
clock  in  1  system clock; all state updates on rising edge
resetn  in  1  asynchronous active-low reset
dig_strobe  in  1  one-cycle pulse: digit key
dig_code  in  4  digit value 0..9 (values 10..15 ignored)
op_strobe  in  1  one-cycle pulse: operator key
op_code  in  2  00 add, 01 subtract; 10/11 ignored
ex_strobe  in  1  one-cycle pulse: execute
clear_strobe  in  1  one-cycle pulse: clear entry/state
neg_strobe  in  1  one-cycle pulse: toggle sign of current entry
bksp_strobe  in  1  one-cycle pulse: delete last digit
ms_strobe, mr_strobe, mc_strobe  in  1 each  memory store/recall/clear
disp_bcd  out  4*DIGITS  displayed magnitude; nibble 0 = units
disp_neg  out  1  displayed value is negative
state_led  out  3  FSM state code
busy  out  1  execution in progress
error  out  1  overflow latched
mem_valid  out  1  memory register holds a stored value

Behaviour:
- Reset (async, resetn=0): A, B, memory = 0 and positive; digit counts = 0; operator = add; state ENTER_A; disp_bcd = 0; disp_neg = 0; busy = 0; error = 0; mem_valid = 0.
- Registers: A and B are sign + DIGITS nibbles + count (0..DIGITS). M is sign + DIGITS nibbles.
- Sign of zero is forced positive. disp_neg = sign AND magnitude != 0.
- States and state_led codes:
  - ENTER_A 000
  - OP_SEL 001
  - ENTER_B 010
  - EXEC_CMP 011
  - EXEC_ALU 100
  - RESULT 101
  - ERROR 110
- Display: ENTER_A, OP_SEL and RESULT show A. ENTER_B shows B. EXEC states hold the previous display. ERROR shows every nibble 4'hE with disp_neg = 0.
- Strobe priority when several arrive in one cycle: clear > ex > op > neg > bksp > dig > ms > mr > mc. Only the highest-priority strobe acts.
- Digit entry (ENTER_A / ENTER_B, applies to the current register):
  - If count < DIGITS: shift magnitude left one nibble, insert digit at nibble 0, count++.
  - If count == DIGITS: digit ignored.
  - Digit 0 when count == 0 leaves the register at 0 and count at 0.
- bksp: magnitude shifts right one nibble (zero fill); count-- saturating at 0. Ignored outside entry states.
- neg: toggles the current register's sign in ENTER_A/ENTER_B. In RESULT, toggles A's sign.
- op:
  - In ENTER_A or RESULT: latch operator, clear B, go to OP_SEL. A result chains as the next A.
  - In OP_SEL: replace the operator.
  - Ignored in ENTER_B.
- dig in OP_SEL: go to ENTER_B and load the digit into B the same cycle.
- dig in RESULT: clear A, load the digit into A, go to ENTER_A.
- ex:
  - In ENTER_B: go to EXEC_CMP, busy=1.
  - Ignored in ENTER_A and OP_SEL.
  - In RESULT: re-executes A op B with B held.
- EXEC_CMP, exactly DIGITS cycles: compares |A| and |B| MSD first.
- EXEC_ALU, exactly DIGITS cycles: processes one digit per cycle, LSD first, with a registered carry/borrow.
  - Effective add (add with equal signs, or subtract with differing signs): result sign = sign A.
  - Otherwise: the larger magnitude minus the smaller; sign = sign of the larger (subtract-B inverts B's sign); equal magnitudes give +0.
- Latency: busy rises the cycle after ex_strobe and stays high 2*DIGITS cycles. The result is written to A, count is set to the significant-digit count, and the state enters RESULT on the following edge.
- Overflow: carry-out from the MSD on an effective add → ERROR, error=1. A is unchanged.
- Strobes other than clear are ignored while busy or in ERROR.
- clear: from any state, including mid-execution, A=B=0, state ENTER_A, busy=0, error=0. Memory is unaffected.
- ms: in ENTER_A, ENTER_B or RESULT, copy the displayed value (sign + magnitude) to M; mem_valid=1.
- mr: only when mem_valid=1.
  - ENTER_A / RESULT: load M into A, go to ENTER_A.
  - OP_SEL / ENTER_B: load M into B, go to ENTER_B.
  - Count is set to the significant-digit count.
- mc: M=0, mem_valid=0.
- Reset asserted mid-execution aborts immediately to reset values.

Test Plan:
- DIGITS=3, enter 1,2,3, op=add, enter 4,5,6, ex → busy high exactly 6 cycles; then disp_bcd=0x579, disp_neg=0, state_led=101.
- Enter 250, op=sub, enter 999, ex → disp_bcd=0x749, disp_neg=1. Then op=add, enter 749, ex → 0x000, disp_neg=0.
- Enter 999, add, enter 1, ex → error=1, disp_bcd=0xEEE, state_led=110. Digit strobes ignored. clear → disp_bcd=0x000, error=0, state ENTER_A.
- Enter 1,2,3,4 → 0x123 (4 ignored). bksp → 0x012. neg → disp_neg=1. bksp×3 → 0x000, disp_neg=0.
- Enter 42, ms → mem_valid=1. clear, mr → A=0x042. mc → mem_valid=0, mr ignored. resetn pulse → mem_valid=0.
- Simultaneous clear_strobe+dig_strobe → clear wins, display 0. resetn low during EXEC_ALU → busy=0 asynchronously, all outputs at reset values.
